// File: rtl/tff_bank.sv
// Bank of WIDTH independent toggle/set/clear/load flip-flops.
// Each flip-flop has a saturating counter of its own state transitions.
module tff_bank #(
    parameter int unsigned      WIDTH   = 4,
    parameter int unsigned      CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic [1:0]               i_mode,
    input  logic [WIDTH-1:0]         i_t,
    input  logic [WIDTH-1:0]         i_d,
    input  logic                     i_cnt_clr,
    output logic [WIDTH-1:0]         o_q,
    output logic                     o_changed,
    output logic [WIDTH*CNT_W-1:0]   o_cnt
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_SET    = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_LOAD   = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        q_d = q_q;
        if (i_en) begin
            case (mode_e'(i_mode))
                MODE_TOGGLE: q_d = q_q ^ i_t;
                MODE_SET:    q_d = q_q | i_t;
                MODE_CLEAR:  q_d = q_q & ~i_t;
                MODE_LOAD:   q_d = (q_q & ~i_t) | (i_d & i_t);
                default:     q_d = q_q;
            endcase
        end
        // q_d equals q_q when disabled, so the flag drops to 0 on its own
        changed_d = |(q_d ^ q_q);
    end

    always_comb begin
        for (int unsigned k = 0; k < WIDTH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (i_cnt_clr) begin
                cnt_d[k] = '0;
            end else if ((q_d[k] != q_q[k]) && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= RST_VAL;
            changed_q <= 1'b0;
            for (int unsigned k = 0; k < WIDTH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
            for (int unsigned k = 0; k < WIDTH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        o_cnt = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            o_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    assign o_q       = q_q;
    assign o_changed = changed_q;

endmodule
